i2s_rx: RTL

I2S receiver (deserializer), the capture-side counterpart of the PmodI2S transmitter. It samples an externally clocked I2S stream (sclk, lrclk, sdata) on the system clock and recovers left and right words. It presents each stereo pair with a one-cycle valid strobe, so an external ADC codec can feed the same filter/echo datapath that PmodMIC feeds today.

---
 rtl/audio_pkg.sv | 8 +
 rtl/i2s_sync.sv | 31 +++
 rtl/i2s_rx.sv | 115 +++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio datapath definitions: default widths and the I2S receiver state type.
package audio_pkg;
    localparam int DATA_W_DEF      = 16;
    localparam int CNT_W_DEF       = 6;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic {ALIGN, RUN} rx_state_t;
endpackage

// File: rtl/i2s_sync.sv
// Multi-flop synchronizer for one async input, with an optional rising-edge strobe.
module i2s_sync #(
    parameter int STAGES  = 2,
    parameter bit EDGE_EN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);
    logic [STAGES-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];

    if (EDGE_EN) begin : g_edge
        logic q_d;
        always_ff @(posedge clk) begin
            if (rst) q_d <= 1'b0;
            else     q_d <= q;
        end
        assign rise = q & ~q_d;
    end else begin : g_no_edge
        assign rise = 1'b0;
    end
endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sclk/lrclk/sdata on clk, aligns to a left-slot start and
// emits left-aligned stereo words with a single-cycle valid strobe.
module i2s_rx
    import audio_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              i2s_sclk,
    input  logic              i2s_lrclk,
    input  logic              i2s_sdata,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              sample_valid,
    output logic              frame_err
);
    logic sck_rise, lr, b;
    logic lr_rise_unused, sd_rise_unused;

    i2s_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(i2s_sclk), .q(), .rise(sck_rise));
    i2s_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_lrclk (
        .clk(clk), .rst(rst), .d(i2s_lrclk), .q(lr), .rise(lr_rise_unused));
    i2s_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_sdata (
        .clk(clk), .rst(rst), .d(i2s_sdata), .q(b), .rise(sd_rise_unused));

    rx_state_t         state_q, state_d;
    logic              lr_q, lr_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, shifted, word;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] left_d, right_d;
    logic              valid_d, err_d, boundary, room;
    int unsigned       pad;

    assign boundary = lr ^ lr_q;
    assign room     = int'(cnt_q) < DATA_W;
    assign shifted  = {shreg_q[DATA_W-2:0], b};

    // Closing word: short slots are padded with zeros in the LSBs.
    always_comb begin
        pad  = '0;
        word = shreg_q;
        if (room) begin
            pad  = DATA_W - 1 - int'(cnt_q);
            word = shifted << pad;
        end
    end

    always_comb begin
        state_d = state_q;
        lr_d    = sck_rise ? lr : lr_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        left_d  = left_data;
        right_d = right_data;
        valid_d = 1'b0;
        err_d   = frame_err;
        if (!en) begin
            state_d = ALIGN;
        end else if (sck_rise) begin
            case (state_q)
                ALIGN: begin
                    if (boundary && lr_q && !lr) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        shreg_d = '0;
                    end
                end
                RUN: begin
                    if (!boundary) begin
                        if (room) shreg_d = shifted;
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    end else begin
                        if (int'(cnt_q) < DATA_W - 1) err_d = 1'b1;
                        if (!lr_q) begin
                            left_d = word;
                        end else begin
                            right_d = word;
                            valid_d = 1'b1;
                        end
                        cnt_d   = '0;
                        shreg_d = '0;
                    end
                end
                default: state_d = ALIGN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ALIGN;
            lr_q         <= 1'b0;
            cnt_q        <= '0;
            shreg_q      <= '0;
            left_data    <= '0;
            right_data   <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lr_q         <= lr_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            left_data    <= left_d;
            right_data   <= right_d;
            sample_valid <= valid_d;
            frame_err    <= err_d;
        end
    end
endmodule
